// File: rtl/serial_magnitude_comparator.sv
// Bit-serial WIDTH-bit magnitude compare fed MSB first by a 1-bit comparator.
// Optional early finish on the first deciding bit: SERIAL_CMP_EARLY_DONE_EN.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          start_in,
  input  logic          bit_valid_in,
  input  logic          g_in,
  input  logic          l_in,
  input  logic          eq_in,
  output logic          busy_out,
  output logic          done_out,
  output logic          g_out,
  output logic          l_out,
  output logic          eq_out,
  output logic          err_out,
  output logic [CW-1:0] bit_cnt_out
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          g_q;
  logic          l_q;
  logic          eq_q;
  logic          err_q;
  logic          dec_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] cnt_q;

  logic          g_nx;
  logic          l_nx;
  logic          eq_nx;
  logic          err_nx;
  logic          dec_nx;
  logic [CW-1:0] cnt_nx;

  logic          legal;
  logic          bit_g;
  logic          bit_l;
  logic          last_bit;
  logic          decide;

  // per-bit decode: an illegal encoding counts as an equal bit
  always_comb begin
    legal = 1'b0;
    unique case ({g_in, l_in, eq_in})
      3'b100,
      3'b010,
      3'b001:  legal = 1'b1;
      default: legal = 1'b0;
    endcase
    bit_g    = legal && g_in;
    bit_l    = legal && l_in;
    last_bit = (cnt_q == CW'(WIDTH - 1));
    decide   = !dec_q && (bit_g || bit_l);
  end

  // next state and next result registers
  always_comb begin
    state_nx = state;
    g_nx     = g_q;
    l_nx     = l_q;
    eq_nx    = eq_q;
    err_nx   = err_q;
    dec_nx   = dec_q;
    cnt_nx   = cnt_q;
    unique case (state)
      IDLE: begin
        if (start_in) begin
          state_nx = RUN;
          g_nx     = 1'b0;
          l_nx     = 1'b0;
          eq_nx    = 1'b0;
          err_nx   = 1'b0;
          dec_nx   = 1'b0;
          cnt_nx   = '0;
        end
      end
      RUN: begin
        if (bit_valid_in) begin
          if (cnt_q != CW'(WIDTH))
            cnt_nx = cnt_q + CW'(1);
          if (!legal)
            err_nx = 1'b1;
          if (decide) begin
            dec_nx = 1'b1;
            g_nx   = bit_g;
            l_nx   = bit_l;
          end
          if (last_bit) begin
            state_nx = DONE;
            if (!dec_q && !decide)
              eq_nx = 1'b1;
          end
`ifdef SERIAL_CMP_EARLY_DONE_EN
          if (decide)
            state_nx = DONE;
`endif
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // state and output registers, synchronous reset wins over everything
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state  <= IDLE;
      g_q    <= 1'b0;
      l_q    <= 1'b0;
      eq_q   <= 1'b0;
      err_q  <= 1'b0;
      dec_q  <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      g_q    <= g_nx;
      l_q    <= l_nx;
      eq_q   <= eq_nx;
      err_q  <= err_nx;
      dec_q  <= dec_nx;
      cnt_q  <= cnt_nx;
      busy_q <= (state_nx == RUN);
      done_q <= (state_nx == DONE);
    end
  end

  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign g_out       = g_q;
  assign l_out       = l_q;
  assign eq_out      = eq_q;
  assign err_out     = err_q;
  assign bit_cnt_out = cnt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Randomized and directed bench for serial_magnitude_comparator, WIDTH=4.
// Expected results come from whole-operand arithmetic on A and B.
module tb_serial_magnitude_comparator;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          bv = 1'b0;
  logic          gi = 1'b0;
  logic          li = 1'b0;
  logic          ei = 1'b0;
  logic          busy;
  logic          done;
  logic          go;
  logic          lo;
  logic          eo;
  logic          err;
  logic [CW-1:0] cnt;

  int n_chk  = 0;
  int n_fail = 0;

  serial_magnitude_comparator #(.WIDTH(W)) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .start_in    (start),
    .bit_valid_in(bv),
    .g_in        (gi),
    .l_in        (li),
    .eq_in       (ei),
    .busy_out    (busy),
    .done_out    (done),
    .g_out       (go),
    .l_out       (lo),
    .eq_out      (eo),
    .err_out     (err),
    .bit_cnt_out (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".g"}, go, 0);
    chk({tag, ".l"}, lo, 0);
    chk({tag, ".eq"}, eo, 0);
    chk({tag, ".err"}, err, 0);
    chk({tag, ".cnt"}, cnt, 0);
  endtask

  // emap: bit positions presented with an illegal encoding
  // gap2: idle cycles before the third bit; rgap: random extra gaps
  // rstart: raise start together with the second bit
  // hold: idle cycles after done in which results must stay put
  task automatic compare(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] emap, input int gap2,
                         input bit rgap, input bit rstart,
                         input int hold);
    logic [W-1:0] am, bm, d, top;
    logic [2:0]   pat;
    int           n, idx;
    bit           xg, xl, xe, xerr;
    am = a & ~emap;
    bm = b & ~emap;
    d  = am ^ bm;
    xg = am > bm;
    xl = am < bm;
    xe = am == bm;
    n  = W;
`ifdef SERIAL_CMP_EARLY_DONE_EN
    for (int i = 0; i < W; i++)
      if (d[i]) n = W - i;
`endif
    top = '0;
    for (int i = 0; i < n; i++) top[W-1-i] = 1'b1;
    xerr = |(emap & top);

    start = 1'b1;
    step();
    start = 1'b0;
    chk("start.busy", busy, 1);
    chk("start.err_clr", err, 0);
    chk("start.res_clr", {go, lo, eo}, 0);
    for (int k = 0; k < n; k++) begin
      int g = (k == 2) ? gap2 : 0;
      if (rgap) g += $urandom_range(0, 2);
      repeat (g) begin
        step();
        chk("stall.cnt", cnt, k);
        chk("stall.busy", busy, 1);
      end
      idx = W - 1 - k;
      if (emap[idx]) begin
        pat = 3'b110;
        if (rgap) begin
          int r = $urandom_range(0, 3);
          if (r == 1) pat = 3'b000;
          if (r == 2) pat = 3'b111;
          if (r == 3) pat = 3'b011;
        end
      end else begin
        pat = {a[idx] & ~b[idx], ~a[idx] & b[idx], a[idx] == b[idx]};
      end
      {gi, li, ei} = pat;
      bv = 1'b1;
      if (rstart && k == 1) start = 1'b1;
      step();
      bv = 1'b0;
      start = 1'b0;
      chk("bit.cnt", cnt, k + 1);
      if (k < n - 1) begin
        chk("bit.busy", busy, 1);
        chk("bit.done", done, 0);
      end
    end
    chk("done.pulse", done, 1);
    chk("done.busy", busy, 0);
    chk("done.g", go, xg);
    chk("done.l", lo, xl);
    chk("done.eq", eo, xe);
    chk("done.err", err, xerr);
    chk("done.cnt", cnt, n);
    step();
    chk("after.done", done, 0);
    chk("after.busy", busy, 0);
    repeat (hold) begin
      step();
      chk("hold.done", done, 0);
      chk("hold.res", {go, lo, eo}, {xg, xl, xe});
      chk("hold.cnt", cnt, n);
    end
  endtask

  initial begin
    step();
    step();
    chk_idle_zero("reset");
    rst = 1'b0;
    step();
    chk_idle_zero("idle");

    compare(4'b1010, 4'b1001, 4'b0000, 0, 1'b0, 1'b0, 0);
    compare(4'b0110, 4'b0110, 4'b0000, 2, 1'b0, 1'b0, 0);
    compare(4'b0011, 4'b1000, 4'b0000, 0, 1'b0, 1'b0, 5);
    compare(4'b0101, 4'b0101, 4'b0100, 0, 1'b0, 1'b0, 0);
    compare(4'b0101, 4'b0101, 4'b0000, 0, 1'b0, 1'b0, 0);

    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      {gi, li, ei} = 3'b001;
      bv = 1'b1;
      step();
    end
    bv = 1'b0;
    chk("prerst.cnt", cnt, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_zero("abort");
    step();
    chk("abort.nodone", done, 0);
    chk("abort.busy", busy, 0);
    compare(4'b1111, 4'b0000, 4'b0000, 0, 1'b0, 1'b0, 0);

    compare(4'b0110, 4'b0110, 4'b0000, 0, 1'b0, 1'b1, 0);
    compare(4'b1100, 4'b0100, 4'b0000, 0, 1'b0, 1'b1, 0);

    bv = 1'b1;
    {gi, li, ei} = 3'b100;
    step();
    step();
    bv = 1'b0;
    chk("idle_bits.cnt", cnt, 4);
    chk("idle_bits.busy", busy, 0);

    for (int t = 0; t < 60; t++) begin
      logic [W-1:0] a, b, e;
      a = W'($urandom);
      b = W'($urandom);
      e = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      compare(a, b, e, $urandom_range(0, 1), 1'b1, 1'($urandom),
              $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
